// File: rtl/spectrum_pkg.sv
// Constants and state encoding shared by the spectrum RAM writer and the peak-search reader.
package spectrum_pkg;

    localparam int SPEC_DATA_W      = 10;
    localparam int SPEC_ADDR_W      = 11;
    localparam int SPEC_NUM_BINS    = 512;
    localparam int SPEC_IMAG_OFFSET = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WRITE_R,
        WRITE_I,
        DONE
    } sw_state_t;

endpackage

// File: rtl/spectrum_writer.sv
// Writes a frame of complex bins into the spectrum RAM (real at bin, imag at bin+IMAG_OFFSET).
// Optional in_last consistency check: define SPECTRUM_WRITER_LAST_CHECK_EN.
module spectrum_writer
    import spectrum_pkg::*;
#(
    parameter int DATA_W      = SPEC_DATA_W,
    parameter int ADDR_W      = SPEC_ADDR_W,
    parameter int NUM_BINS    = SPEC_NUM_BINS,
    parameter int IMAG_OFFSET = SPEC_IMAG_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);
    localparam logic [ADDR_W-1:0] IMAG_OFS = ADDR_W'(IMAG_OFFSET);

    sw_state_t                state, state_n;
    logic [ADDR_W-1:0]        index, index_n;
    logic signed [DATA_W-1:0] cap_im, cap_im_n;
    logic                     ready_n, we_n, busy_n, done_n;
    logic [ADDR_W-1:0]        addr_n;
    logic [DATA_W-1:0]        data_n;
    logic                     start_acc;
    logic                     accept;

    // start only counts when no frame is in flight
    assign start_acc = start && (state == IDLE || state == DONE);
    assign accept    = (state == CAPTURE) && in_valid && in_ready;

    always_comb begin
        state_n  = state;
        index_n  = index;
        cap_im_n = cap_im;
        ready_n  = 1'b0;
        we_n     = 1'b0;
        addr_n   = mem_addr;
        data_n   = mem_data;
        busy_n   = busy;
        done_n   = frame_done;
        case (state)
            IDLE, DONE: begin
                if (start_acc) begin
                    index_n = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    ready_n = 1'b1;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    // real part goes straight to the write port; imag waits one cycle
                    cap_im_n = in_im;
                    we_n     = 1'b1;
                    addr_n   = index;
                    data_n   = in_re;
                    state_n  = WRITE_R;
                end else begin
                    ready_n = 1'b1;
                end
            end
            WRITE_R: begin
                we_n    = 1'b1;
                addr_n  = index + IMAG_OFS;
                data_n  = cap_im;
                state_n = WRITE_I;
            end
            WRITE_I: begin
                if (index == LAST_IDX) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    index_n = index + 1'b1;
                    ready_n = 1'b1;
                    state_n = CAPTURE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            index      <= '0;
            cap_im     <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            index      <= index_n;
            cap_im     <= cap_im_n;
            in_ready   <= ready_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_data   <= data_n;
            busy       <= busy_n;
            frame_done <= done_n;
        end
    end

`ifdef SPECTRUM_WRITER_LAST_CHECK_EN
    logic cap_last;
    logic err_q;

    // in_last must coincide exactly with the final bin; frame length still follows NUM_BINS
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_last <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) cap_last <= in_last;
            if (start_acc) err_q <= 1'b0;
            else if (state == WRITE_I && (cap_last != (index == LAST_IDX))) err_q <= 1'b1;
        end
    end

    assign frame_err = err_q;
`else
    logic unused_last;
    assign unused_last = in_last;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spectrum_writer.sv
// Directed bench for spectrum_writer: a 4-bin instance for frame sequencing and a default 512-bin instance.
`timescale 1ns/1ps
module tb_spectrum_writer;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst, start, start_full, in_valid, in_last;
    logic [9:0] in_re, in_im;

    logic        ready, we, busy, done, err;
    logic [10:0] addr;
    logic [9:0]  data;
    logic        f_ready, f_we, f_busy, f_done, f_err;
    logic [10:0] f_addr;
    logic [9:0]  f_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spectrum_writer #(.DATA_W(10), .ADDR_W(11), .NUM_BINS(NB), .IMAG_OFFSET(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .mem_we(we), .mem_addr(addr),
        .mem_data(data), .busy(busy), .frame_done(done), .frame_err(err)
    );

    spectrum_writer dut_full (
        .clk(clk), .rst(rst), .start(start_full), .in_valid(in_valid), .in_ready(f_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last), .mem_we(f_we), .mem_addr(f_addr),
        .mem_data(f_data), .busy(f_busy), .frame_done(f_done), .frame_err(f_err)
    );

    int log_addr[$];
    int log_data[$];
    int overlap = 0;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            log_addr.push_back(int'(addr));
            log_data.push_back(int'($signed(data)));
            if (ready === 1'b1) overlap++;
        end
    end

    function automatic int f_re(int k);
        return k - 256;
    endfunction

    function automatic int f_im(int k);
        return 511 - 2 * k;
    endfunction

    int fw = 0;
    int fmis = 0;
    int f_first[2];

    always @(negedge clk) begin
        int b, ea, ed;
        if (f_we === 1'b1) begin
            b  = fw / 2;
            ea = (fw % 2 == 1) ? b + 1024 : b;
            ed = (fw % 2 == 1) ? f_im(b) : f_re(b);
            if (fw < 2) f_first[fw] = int'(f_addr);
            if (int'(f_addr) != ea || int'($signed(f_data)) != ed) fmis++;
            fw++;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int bre[4];
    int bim[4];

    task automatic run_frame(input bit gaps, input int last_k, input int mid_start,
                             input int abort_cyc, output int done_cyc);
        int k = 0;
        int cyc;
        bit acc;
        done_cyc = -1;
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk("start_busy", busy, 1);
        chk("start_ready", ready, 1);
        chk("start_done_clr", done, 0);
        while (k < NB && cyc < 200) begin
            if (abort_cyc > 0 && cyc == abort_cyc) break;
            in_re    = 10'(bre[k]);
            in_im    = 10'(bim[k]);
            in_last  = (k == last_k);
            in_valid = gaps ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            start    = (cyc == mid_start);
            acc      = ready && in_valid;
            @(negedge clk);
            cyc++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (abort_cyc > 0) return;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (done === 1'b1) done_cyc = cyc;
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_nwrites"}, log_addr.size(), 2 * NB);
        for (int i = 0; i < NB; i++) begin
            if (log_addr.size() >= 2 * i + 2) begin
                chk($sformatf("%s_re_addr%0d", tag, i), log_addr[2*i], i);
                chk($sformatf("%s_re_data%0d", tag, i), log_data[2*i], bre[i]);
                chk($sformatf("%s_im_addr%0d", tag, i), log_addr[2*i+1], i + 1024);
                chk($sformatf("%s_im_data%0d", tag, i), log_data[2*i+1], bim[i]);
            end
        end
    endtask

    initial begin
        int dc, k, cyc;
        bit acc;
        rst = 1'b1; start = 1'b0; start_full = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_re = '0; in_im = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_full_done", f_done, 0);

        // input presented while idle must be ignored
        in_valid = 1'b1; in_re = 10'd7; in_im = 10'd9;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", ready, 0);
            chk("idle_we", we, 0);
        end
        in_valid = 1'b0;

        // basic frame
        bre = '{1, 2, -3, 511};
        bim = '{-1, -2, 3, -512};
        log_addr.delete(); log_data.delete();
        run_frame(1'b0, 3, -1, -1, dc);
        chk("basic_done_cycle", dc, 13);
        chk_log("basic");
        chk("basic_err", err, 0);
        chk("basic_busy_done", busy, 0);

        // restart from DONE with a gappy in_valid
        bre = '{5, -100, 255, 0};
        bim = '{-5, 100, -256, -1};
        log_addr.delete(); log_data.delete();
        run_frame(1'b1, 3, -1, -1, dc);
        chk("gaps_done_seen", dc > 0, 1);
        chk_log("gaps");

        // start pulsed while capturing bin 2 has no effect
        bre = '{-512, 17, -17, 100};
        bim = '{511, -33, 33, -100};
        log_addr.delete(); log_data.delete();
        run_frame(1'b0, 3, 7, -1, dc);
        chk("midstart_done_cycle", dc, 13);
        chk_log("midstart");

        // reset after two bins are written
        log_addr.delete(); log_data.delete();
        run_frame(1'b0, 3, -1, 6, dc);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_we", we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_nwrites", log_addr.size(), 4);
        log_addr.delete(); log_data.delete();
        run_frame(1'b0, 3, -1, -1, dc);
        chk("after_rst_done_cycle", dc, 13);
        chk_log("after_rst");

        // in_last on the wrong bin
        log_addr.delete(); log_data.delete();
        run_frame(1'b0, 1, -1, -1, dc);
        chk("last_done_cycle", dc, 13);
        chk_log("last");
`ifdef SPECTRUM_WRITER_LAST_CHECK_EN
        chk("last_err_set", err, 1);
`else
        chk("last_err_set", err, 0);
`endif
        log_addr.delete(); log_data.delete();
        run_frame(1'b0, 3, -1, -1, dc);
        chk("last_err_cleared", err, 0);
        chk("overlap_ready_we", overlap, 0);

        // full-size frame on the default instance, then restart from DONE
        fw = 0; fmis = 0;
        k = 0;
        in_last = 1'b0;
        in_re = 10'(f_re(0)); in_im = 10'(f_im(0));
        start_full = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        start_full = 1'b0;
        cyc = 1;
        while (f_done !== 1'b1 && cyc < 2000) begin
            in_re = 10'(f_re(k));
            in_im = 10'(f_im(k));
            acc = f_ready;
            @(negedge clk);
            cyc++;
            if (acc) k++;
        end
        chk("full_done_cycle", cyc, 3 * 512 + 1);
        chk("full_nwrites", fw, 1024);
        chk("full_mismatches", fmis, 0);
        chk("full_busy_done", f_busy, 0);

        fw = 0; fmis = 0; k = 0;
        in_re = 10'(f_re(0)); in_im = 10'(f_im(0));
        start_full = 1'b1;
        @(negedge clk);
        start_full = 1'b0;
        chk("full_restart_done_clr", f_done, 0);
        chk("full_restart_busy", f_busy, 1);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("full_restart_first_re", f_first[0], 0);
        chk("full_restart_first_im", f_first[1], 1024);
        chk("full_restart_mismatches", fmis, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
